// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR read-data launcher.
// DQS patterns are {high half, low half} of one CK cycle.
package ddr_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} drv_state_e;

  localparam int unsigned DATA_CYC_BL8 = 4;
  localparam int unsigned DATA_CYC_BC4 = 2;

  localparam logic [1:0] DQS_T_DATA      = 2'b10;
  localparam logic [1:0] DQS_T_PRE_EARLY = 2'b10;
  localparam logic [1:0] DQS_T_PRE_LAST  = 2'b00;
  localparam logic [1:0] DQS_T_POST      = 2'b00;
  localparam logic [1:0] DQS_OE_FULL     = 2'b11;
  localparam logic [1:0] DQS_OE_POST     = 2'b10;

  // Data cycles remaining after the first one of a burst.
  function automatic logic [1:0] extra_data_cycles(input logic bc4);
    return bc4 ? 2'(DATA_CYC_BC4 - 1) : 2'(DATA_CYC_BL8 - 1);
  endfunction

endpackage

// File: rtl/ddr_rd_burst_drv_if.sv
// Read-request handshake from the command decoder into the data launcher.
interface ddr_rd_burst_drv_if #(
  parameter int unsigned DQ_W = 8
) ();

  logic                rd_valid;
  logic                rd_ready;
  logic                rd_bc4;
  logic [8*DQ_W-1:0]   rd_data;

  modport master (output rd_valid, output rd_bc4, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_bc4, input rd_data, output rd_ready);

endinterface

// File: rtl/ddr_rd_fifo.sv
// Synchronous FIFO holding accepted read bursts until their first data cycle.
module ddr_rd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge CK_t) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CntW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/ddr_rd_burst_drv.sv
// DRAM-model read-data launcher: queues read bursts, waits CAS latency, then drives
// DQ/DQS with preamble, seamless back-to-back bursts and half-cycle postamble.
module ddr_rd_burst_drv
  import ddr_pkg::*;
#(
  parameter int unsigned DQ_W    = 8,
  parameter int unsigned CL      = 11,
  parameter int unsigned PRE_CYC = 1,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic                CK_t,
  input  logic                reset_n,
  ddr_rd_burst_drv_if.slave   rd_if,
  output logic [DQ_W-1:0]     dq_rise,
  output logic [DQ_W-1:0]     dq_fall,
  output logic                dq_oe,
  output logic [1:0]          dqs_t_hl,
  output logic [1:0]          dqs_oe_hl,
  output logic                busy,
  output logic                burst_done
);

  typedef struct packed {
    logic              bc4;
    logic [8*DQ_W-1:0] data;
  } rd_burst_t;

  localparam int unsigned       RemW    = $clog2(CL + DATA_CYC_BL8);
  localparam logic [RemW-1:0]   REM_BL8 = RemW'(CL + DATA_CYC_BL8 - 1);
  localparam logic [RemW-1:0]   REM_BC4 = RemW'(CL + DATA_CYC_BC4 - 1);

  rd_burst_t         w_push_burst;
  rd_burst_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_start;
  logic              w_pre_last;
  logic              w_pre_early;

  logic [CL-1:0]     r_dly;
  logic [RemW-1:0]   r_rem;
  drv_state_e        r_state;
  logic [1:0]        r_left;
  logic [8*DQ_W-1:0] r_shift;

  assign w_push_burst   = {rd_if.rd_bc4, rd_if.rd_data};
  assign rd_if.rd_ready = ~w_full & (r_rem <= RemW'(CL));
  assign w_accept       = rd_if.rd_valid & rd_if.rd_ready;

  // r_dly[j] set means a burst's first data cycle is j cycles after the current one.
  assign w_start     = r_dly[1];
  assign w_pre_last  = r_dly[2];
  assign w_pre_early = (PRE_CYC == 2) ? r_dly[3] : 1'b0;

  assign busy = ~w_empty | (r_state != IDLE) | (|r_dly);

  ddr_rd_fifo #(
    .Width ($bits(rd_burst_t)),
    .Depth (Q_DEPTH)
  ) u_fifo (
    .CK_t    (CK_t),
    .reset_n (reset_n),
    .i_push  (w_accept),
    .i_wdata (w_push_burst),
    .i_pop   (w_start),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_dly <= '0;
      r_rem <= '0;
    end else begin
      r_dly <= {w_accept, r_dly[CL-1:1]};
      if (w_accept)        r_rem <= rd_if.rd_bc4 ? REM_BC4 : REM_BL8;
      else if (r_rem != 0) r_rem <= r_rem - RemW'(1);
    end
  end

  // Outputs are registered: each edge computes the pattern for the cycle it opens.
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_left     <= '0;
      r_shift    <= '0;
      dq_rise    <= '0;
      dq_fall    <= '0;
      dq_oe      <= 1'b0;
      dqs_t_hl   <= 2'b00;
      dqs_oe_hl  <= 2'b00;
      burst_done <= 1'b0;
    end else if (r_state == DATA && r_left != 2'd0) begin
      r_state    <= DATA;
      r_left     <= r_left - 2'd1;
      r_shift    <= r_shift >> (2 * DQ_W);
      dq_rise    <= r_shift[0 +: DQ_W];
      dq_fall    <= r_shift[DQ_W +: DQ_W];
      dq_oe      <= 1'b1;
      dqs_t_hl   <= DQS_T_DATA;
      dqs_oe_hl  <= DQS_OE_FULL;
      burst_done <= (r_left == 2'd1);
    end else if (w_start) begin
      r_state    <= DATA;
      r_left     <= extra_data_cycles(w_head.bc4);
      r_shift    <= w_head.data >> (2 * DQ_W);
      dq_rise    <= w_head.data[0 +: DQ_W];
      dq_fall    <= w_head.data[DQ_W +: DQ_W];
      dq_oe      <= 1'b1;
      dqs_t_hl   <= DQS_T_DATA;
      dqs_oe_hl  <= DQS_OE_FULL;
      burst_done <= 1'b0;
    end else if (w_pre_last || w_pre_early) begin
      // Short gaps land here directly from DATA, skipping the postamble.
      r_state    <= PRE;
      dq_rise    <= '0;
      dq_fall    <= '0;
      dq_oe      <= 1'b0;
      dqs_t_hl   <= w_pre_last ? DQS_T_PRE_LAST : DQS_T_PRE_EARLY;
      dqs_oe_hl  <= DQS_OE_FULL;
      burst_done <= 1'b0;
    end else if (r_state == DATA) begin
      r_state    <= POST;
      dq_rise    <= '0;
      dq_fall    <= '0;
      dq_oe      <= 1'b0;
      dqs_t_hl   <= DQS_T_POST;
      dqs_oe_hl  <= DQS_OE_POST;
      burst_done <= 1'b0;
    end else begin
      r_state    <= IDLE;
      dq_rise    <= '0;
      dq_fall    <= '0;
      dq_oe      <= 1'b0;
      dqs_t_hl   <= 2'b00;
      dqs_oe_hl  <= 2'b00;
      burst_done <= 1'b0;
    end
  end

endmodule
